// File: rtl/io_seq_pkg.sv
// Shared types and helpers for the IO supply/bias sequencer.
// Holds the FSM state encoding, the timeout counter width and the channel-index width helper.
package io_seq_pkg;

   typedef enum logic [2:0] {
      OFF,
      UP_PG,
      UP_SET,
      ON,
      DN_SET,
      FAULT
   } seq_state_e;

   localparam int TMO_W = 16;

   // Width of a channel index; never less than one bit, even for a single channel.
   function automatic int ch_idx_w(input int n_ch);
      return (n_ch <= 2) ? 1 : $clog2(n_ch);
   endfunction

endpackage

// File: rtl/io_seq_sync2.sv
// Per-bit two-flop synchroniser for asynchronous power-good inputs.
// Both stages reset to 0, so a channel reads "not good" until it is seen twice.
module io_seq_sync2 #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o
);

   logic [W-1:0] meta_q;
   logic [W-1:0] sync_q;

   genvar gi;
   generate
      for (gi = 0; gi < W; gi++) begin : g_bit
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               meta_q[gi] <= 1'b0;
               sync_q[gi] <= 1'b0;
            end else begin
               meta_q[gi] <= d_i[gi];
               sync_q[gi] <= meta_q[gi];
            end
         end
      end
   endgenerate

   assign q_o = sync_q;

endmodule

// File: rtl/io_supply_sequencer.sv
// Power-up/power-down sequencer for N_CH IO-bank supply/bias domains.
// Enables are a registered thermometer code; any timeout or power-good loss drops them all at once.
module io_supply_sequencer
   import io_seq_pkg::*;
#(
   parameter int N_CH    = 4,
   parameter int CNT_W   = 12,
   parameter int TMO_CYC = 1024
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        req_on_i,
   input  logic [CNT_W-1:0]            ramp_dly_i,
   input  logic [N_CH-1:0]             pgood_i,
   input  logic                        err_clr_i,
   output logic [N_CH-1:0]             en_o,
   output logic                        done_o,
   output logic                        off_o,
   output logic                        busy_o,
   output logic                        err_o,
   output logic [ch_idx_w(N_CH)-1:0]   err_ch_o
);

   localparam int                    CH_IDX_W = ch_idx_w(N_CH);
   localparam logic [CH_IDX_W-1:0]   LAST_CH  = CH_IDX_W'(N_CH - 1);
   localparam logic [TMO_W-1:0]      TMO_LAST = TMO_W'(TMO_CYC - 1);

   seq_state_e            state_q, state_d;
   logic [CH_IDX_W-1:0]   k_q, k_d;
   logic [TMO_W-1:0]      tmo_q, tmo_d;
   logic [CNT_W-1:0]      set_q, set_d;
   logic [N_CH-1:0]       en_q, en_d;
   logic                  err_q, err_d;
   logic [CH_IDX_W-1:0]   err_ch_q, err_ch_d;

   logic [N_CH-1:0]       pg_s;
   logic [N_CH-1:0]       below_k, incl_k, incl_kp1, below_km1;
   logic [N_CH-1:0]       mon, lost;
   logic                  lost_any;
   logic [CH_IDX_W-1:0]   lost_idx;
   logic [CNT_W-1:0]      set_dec;
   logic [TMO_W-1:0]      tmo_inc;
   logic                  fault_req;
   logic [CH_IDX_W-1:0]   fault_ch;

   io_seq_sync2 #(
      .W (N_CH)
   ) u_pg_sync (
      .clk (clk),
      .rst (rst),
      .d_i (pgood_i),
      .q_o (pg_s)
   );

   // Thermometer masks relative to the current channel index; building every enable
   // pattern from these keeps en_o a contiguous run from bit 0 by construction.
   genvar gi;
   generate
      for (gi = 0; gi < N_CH; gi++) begin : g_mask
         assign below_k[gi]   = (gi < int'(k_q));
         assign incl_k[gi]    = (gi <= int'(k_q));
         assign incl_kp1[gi]  = (gi <= int'(k_q) + 1);
         assign below_km1[gi] = (gi + 1 < int'(k_q));
      end
   endgenerate

   // Only channels whose power-good has already been confirmed are watched for loss.
   always_comb begin
      mon = '0;
      case (state_q)
         UP_PG:   mon = below_k;
         UP_SET:  mon = incl_k;
         ON:      mon = '1;
         default: mon = '0;
      endcase
   end

   assign lost     = mon & ~pg_s;
   assign lost_any = |lost;

   always_comb begin
      lost_idx = '0;
      for (int i = N_CH - 1; i >= 0; i--) begin
         if (lost[i]) lost_idx = CH_IDX_W'(i);
      end
   end

   assign set_dec = (set_q == '0) ? '0 : set_q - CNT_W'(1);
   assign tmo_inc = (&tmo_q) ? tmo_q : tmo_q + TMO_W'(1);

   always_comb begin
      state_d   = state_q;
      k_d       = k_q;
      tmo_d     = tmo_q;
      set_d     = set_q;
      en_d      = en_q;
      err_d     = err_q;
      err_ch_d  = err_ch_q;
      fault_req = 1'b0;
      fault_ch  = k_q;

      case (state_q)
         OFF: begin
            if (req_on_i) begin
               k_d     = '0;
               tmo_d   = '0;
               en_d    = N_CH'(1);
               state_d = UP_PG;
            end
         end

         UP_PG: begin
            if (lost_any) begin
               fault_req = 1'b1;
               fault_ch  = lost_idx;
            end else if (!req_on_i) begin
               en_d    = below_k;
               set_d   = ramp_dly_i;
               state_d = DN_SET;
            end else if (pg_s[k_q]) begin
               set_d   = ramp_dly_i;
               state_d = UP_SET;
            end else if (tmo_q >= TMO_LAST) begin
               fault_req = 1'b1;
               fault_ch  = k_q;
            end else begin
               tmo_d = tmo_inc;
            end
         end

         UP_SET: begin
            if (lost_any) begin
               fault_req = 1'b1;
               fault_ch  = lost_idx;
            end else if (!req_on_i) begin
               en_d    = below_k;
               set_d   = ramp_dly_i;
               state_d = DN_SET;
            end else if (set_q <= CNT_W'(1)) begin
               // A load of 0 or 1 both settle for exactly one cycle.
               set_d = set_dec;
               if (k_q == LAST_CH) begin
                  state_d = ON;
               end else begin
                  k_d     = k_q + CH_IDX_W'(1);
                  en_d    = incl_kp1;
                  tmo_d   = '0;
                  state_d = UP_PG;
               end
            end else begin
               set_d = set_dec;
            end
         end

         ON: begin
            if (lost_any) begin
               fault_req = 1'b1;
               fault_ch  = lost_idx;
            end else if (!req_on_i) begin
               k_d     = LAST_CH;
               en_d    = below_k;
               set_d   = ramp_dly_i;
               state_d = DN_SET;
            end
         end

         DN_SET: begin
            if (set_q == '0) begin
               if (req_on_i) begin
                  // Re-request: bring the channel that just went down back up first.
                  en_d    = incl_k;
                  tmo_d   = '0;
                  state_d = UP_PG;
               end else if (k_q != '0) begin
                  k_d   = k_q - CH_IDX_W'(1);
                  en_d  = below_km1;
                  set_d = ramp_dly_i;
               end else begin
                  state_d = OFF;
               end
            end else begin
               set_d = set_dec;
            end
         end

         FAULT: begin
            en_d = '0;
            if (err_clr_i && !req_on_i) begin
               err_d    = 1'b0;
               err_ch_d = '0;
               k_d      = '0;
               tmo_d    = '0;
               set_d    = '0;
               state_d  = OFF;
            end
         end

         default: begin
            en_d    = '0;
            k_d     = '0;
            state_d = OFF;
         end
      endcase

      if (fault_req) begin
         en_d     = '0;
         err_d    = 1'b1;
         err_ch_d = fault_ch;
         state_d  = FAULT;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= OFF;
         k_q      <= '0;
         tmo_q    <= '0;
         set_q    <= '0;
         en_q     <= '0;
         err_q    <= 1'b0;
         err_ch_q <= '0;
      end else begin
         state_q  <= state_d;
         k_q      <= k_d;
         tmo_q    <= tmo_d;
         set_q    <= set_d;
         en_q     <= en_d;
         err_q    <= err_d;
         err_ch_q <= err_ch_d;
      end
   end

   assign en_o     = en_q;
   assign done_o   = (state_q == ON);
   assign off_o    = (state_q == OFF);
   assign busy_o   = (state_q == UP_PG) || (state_q == UP_SET) || (state_q == DN_SET);
   assign err_o    = err_q;
   assign err_ch_o = err_ch_q;

endmodule

// File: tb/tb_io_supply_sequencer.sv
// Directed and randomized bench for io_supply_sequencer (N_CH=4, TMO_CYC=16).
// Expected timing comes from the sequencing rules: up-step period = latency+3+max(ramp,1), down-step = ramp+1.
module tb_io_supply_sequencer;

   localparam int N_CH    = 4;
   localparam int CNT_W   = 12;
   localparam int TMO_CYC = 16;

   logic               clk = 1'b0;
   logic               rst;
   logic               req_on_i;
   logic [CNT_W-1:0]   ramp_dly_i;
   logic [N_CH-1:0]    pgood_i;
   logic               err_clr_i;
   logic [N_CH-1:0]    en_o;
   logic               done_o;
   logic               off_o;
   logic               busy_o;
   logic               err_o;
   logic [1:0]         err_ch_o;

   logic [N_CH-1:0]    pg_up = '0;
   logic [N_CH-1:0]    blk;
   int                 age [N_CH];
   int                 lat = 5;
   int                 cyc = 0;
   int                 tests = 0;
   int                 fails = 0;

   io_supply_sequencer #(
      .N_CH    (N_CH),
      .CNT_W   (CNT_W),
      .TMO_CYC (TMO_CYC)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .req_on_i   (req_on_i),
      .ramp_dly_i (ramp_dly_i),
      .pgood_i    (pgood_i),
      .err_clr_i  (err_clr_i),
      .en_o       (en_o),
      .done_o     (done_o),
      .off_o      (off_o),
      .busy_o     (busy_o),
      .err_o      (err_o),
      .err_ch_o   (err_ch_o)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Supply model: power-good rises once the enable has been high for more than 'lat' cycles.
   always @(negedge clk) begin
      for (int k = 0; k < N_CH; k++) begin
         if (en_o[k] === 1'b1) age[k] = (age[k] < 1000) ? age[k] + 1 : age[k];
         else                  age[k] = 0;
         pg_up[k] = (age[k] > lat);
      end
   end

   assign pgood_i = pg_up & ~blk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic wait_en(input logic [N_CH-1:0] v, output int at, output bit all_busy);
      at = -1;
      all_busy = 1'b1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (busy_o !== 1'b1) all_busy = 1'b0;
         if (en_o === v) begin
            at = cyc;
            break;
         end
      end
   endtask

   task automatic wait_off(output int at);
      at = -1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (off_o === 1'b1) begin
            at = cyc;
            break;
         end
      end
   endtask

   task automatic power_up(input int r, input int l, input string tag);
      int s, at, per;
      bit bz;
      logic [N_CH-1:0] therm;
      per = l + 3 + ((r < 1) ? 1 : r);
      lat = l;
      ramp_dly_i = CNT_W'(r);
      @(negedge clk);
      s = cyc;
      req_on_i = 1'b1;
      for (int j = 0; j < N_CH; j++) begin
         therm = N_CH'((1 << (j + 1)) - 1);
         wait_en(therm, at, bz);
         chk({tag, " up-step time"}, at - s, 1 + j * per);
         chk({tag, " busy while ramping"}, 32'(bz), 1);
      end
      at = -1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (done_o === 1'b1) begin
            at = cyc;
            break;
         end
      end
      chk({tag, " done time"}, at - s, 1 + N_CH * per);
      chk({tag, " en all on"}, 32'(en_o), 32'(4'b1111));
      $display("[TB] %s: power-up ramp=%0d lat=%0d period=%0d", tag, r, l, per);
   endtask

   task automatic power_down(input int r, input string tag);
      int s, at;
      bit bz;
      logic [N_CH-1:0] therm;
      ramp_dly_i = CNT_W'(r);
      @(negedge clk);
      s = cyc;
      req_on_i = 1'b0;
      for (int j = 1; j <= N_CH; j++) begin
         therm = N_CH'((1 << (N_CH - j)) - 1);
         wait_en(therm, at, bz);
         chk({tag, " down-step time"}, at - s, 1 + (j - 1) * (r + 1));
      end
      wait_off(at);
      chk({tag, " off time"}, at - s, 1 + N_CH * (r + 1));
      chk({tag, " done low"}, 32'(done_o), 0);
      $display("[TB] %s: power-down ramp=%0d spacing=%0d", tag, r, r + 1);
   endtask

   initial begin
      int s, at, a, r, l;
      bit bz;

      rst = 1'b1;
      req_on_i = 1'b0;
      err_clr_i = 1'b0;
      ramp_dly_i = '0;
      blk = '0;

      // Reset state
      repeat (3) @(negedge clk);
      chk("reset en", 32'(en_o), 0);
      chk("reset done", 32'(done_o), 0);
      chk("reset off", 32'(off_o), 1);
      chk("reset busy", 32'(busy_o), 0);
      chk("reset err", 32'(err_o), 0);
      chk("reset err_ch", 32'(err_ch_o), 0);
      rst = 1'b0;
      $display("[TB] reset: outputs checked");

      // Directed nominal sequence
      power_up(3, 5, "nominal");
      power_down(3, "nominal");

      // Randomized sequences
      for (int t = 0; t < 3; t++) begin
         r = $urandom_range(0, 6);
         l = $urandom_range(1, 8);
         power_up(r, l, "random");
         power_down($urandom_range(0, 5), "random");
      end

      // Power-good timeout on channel 2
      blk = 4'b0100;
      lat = 2;
      ramp_dly_i = CNT_W'(1);
      @(negedge clk);
      req_on_i = 1'b1;
      wait_en(4'b0111, a, bz);
      chk("tmo en2 reached", 32'(a > 0), 1);
      wait_en(4'b0000, at, bz);
      chk("tmo fault time", at - a, TMO_CYC);
      chk("tmo err", 32'(err_o), 1);
      chk("tmo err_ch", 32'(err_ch_o), 2);
      chk("tmo busy", 32'(busy_o), 0);
      err_clr_i = 1'b1;
      @(negedge clk);
      err_clr_i = 1'b0;
      chk("tmo clr ignored err", 32'(err_o), 1);
      chk("tmo clr ignored off", 32'(off_o), 0);
      req_on_i = 1'b0;
      @(negedge clk);
      chk("tmo held without clr", 32'(err_o), 1);
      err_clr_i = 1'b1;
      @(negedge clk);
      err_clr_i = 1'b0;
      chk("tmo cleared err", 32'(err_o), 0);
      chk("tmo cleared off", 32'(off_o), 1);
      chk("tmo cleared err_ch", 32'(err_ch_o), 0);
      blk = '0;
      $display("[TB] timeout: channel 2 fault and clear checked");

      // Simultaneous power-good loss on channels 1 and 3 while ON
      power_up(2, 3, "pgdrop");
      @(negedge clk);
      blk = 4'b1010;
      @(negedge clk);
      chk("pgdrop sync stage 1", 32'(en_o), 32'(4'b1111));
      @(negedge clk);
      chk("pgdrop sync stage 2", 32'(en_o), 32'(4'b1111));
      @(negedge clk);
      chk("pgdrop en cleared", 32'(en_o), 0);
      chk("pgdrop err", 32'(err_o), 1);
      chk("pgdrop err_ch lowest", 32'(err_ch_o), 1);
      #2 rst = 1'b1;
      #1;
      chk("pgdrop async rst err", 32'(err_o), 0);
      chk("pgdrop async rst err_ch", 32'(err_ch_o), 0);
      chk("pgdrop async rst off", 32'(off_o), 1);
      @(negedge clk);
      req_on_i = 1'b0;
      blk = '0;
      rst = 1'b0;
      $display("[TB] pgdrop: lowest lost channel and async clear checked");

      // Abort during UP_SET of channel 1, then re-request during the last down-settle
      ramp_dly_i = CNT_W'(2);
      lat = 2;
      @(negedge clk);
      s = cyc;
      req_on_i = 1'b1;
      wait_en(4'b0001, at, bz);
      chk("abort en0 time", at - s, 1);
      wait_en(4'b0011, a, bz);
      chk("abort en1 time", a - s, 1 + 7);
      repeat (lat + 3) @(negedge clk);
      chk("abort in settle en", 32'(en_o), 32'(4'b0011));
      chk("abort in settle busy", 32'(busy_o), 1);
      s = cyc;
      req_on_i = 1'b0;
      wait_en(4'b0001, at, bz);
      chk("abort en1 drop", at - s, 1);
      wait_en(4'b0000, at, bz);
      chk("abort en0 drop", at - s, 1 + 3);
      s = at;
      @(negedge clk);
      req_on_i = 1'b1;
      wait_en(4'b0001, at, bz);
      chk("restart en0 time", at - s, 3);
      chk("restart not off", 32'(off_o), 0);
      s = at;
      wait_en(4'b0011, at, bz);
      chk("restart en1 time", at - s, 7);
      s = cyc;
      req_on_i = 1'b0;
      wait_en(4'b0001, at, bz);
      chk("restart abort drop", at - s, 1);
      wait_off(at);
      chk("restart off time", at - s, 1 + 2 * 3);
      $display("[TB] abort: ramp-down from UP_SET and restart checked");

      // Asynchronous reset while in UP_PG with two channels on
      ramp_dly_i = CNT_W'(1);
      lat = 4;
      @(negedge clk);
      req_on_i = 1'b1;
      wait_en(4'b0011, at, bz);
      chk("rst pre en", 32'(en_o), 32'(4'b0011));
      #2 rst = 1'b1;
      #1;
      chk("async rst en", 32'(en_o), 0);
      chk("async rst off", 32'(off_o), 1);
      chk("async rst err", 32'(err_o), 0);
      chk("async rst busy", 32'(busy_o), 0);
      chk("async rst done", 32'(done_o), 0);
      @(negedge clk);
      req_on_i = 1'b0;
      rst = 1'b0;
      repeat (2) @(negedge clk);
      chk("post rst en", 32'(en_o), 0);
      chk("post rst off", 32'(off_o), 1);
      $display("[TB] reset: asynchronous clear in UP_PG checked");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/io_supply_sequencer.md
Name: io_supply_sequencer

Overview:
Parametrised power-up/power-down sequencer for N_CH IO-bank supply and bias domains (VPW/VDDIO-class cells).
- Asserts per-channel enables in ascending order. Each enable waits for that channel's power-good, then a programmable settle time, before the next channel starts.
- Deasserts in descending order, with the same settle time between channels.
- Detects power-good timeout and power-good loss, and performs an emergency shutdown on either.
- Sits in the always-on digital domain next to the IO ring and drives the enable pins of the supply/bias pad cells.

Parameters:
N_CH, 4, number of sequenced supply/bias channels (1..16)
CNT_W, 12, width of settle counter and ramp_dly_i
TMO_CYC, 1024, max cycles from en_o[k] rise to synchronised pgood[k] before fault (must be < 2^16)

Ports:
clk  in  1  sequencer clock
rst  in  1  asynchronous active-high reset
req_on_i  in  1  level request: 1 = all domains on, 0 = all off
ramp_dly_i  in  CNT_W  settle cycles after each channel step; sampled at each step start
pgood_i  in  N_CH  asynchronous power-good per channel
err_clr_i  in  1  single-cycle pulse; clears FAULT
en_o  out  N_CH  per-channel supply/bias enable
done_o  out  1  all channels on and settled (state ON)
off_o  out  1  all channels off (state OFF)
busy_o  out  1  sequencing in progress
err_o  out  1  fault latched
err_ch_o  out  $clog2(N_CH) (min 1)  channel that caused the fault

Behaviour:
- Reset values: en_o=0, done_o=0, off_o=1, busy_o=0, err_o=0, err_ch_o=0, state=OFF, channel index k=0, counters 0. Reset mid-sequence forces all en_o low immediately (asynchronous).
- pgood_i passes through a 2-flop synchroniser per bit (pg_s); the FSM uses only pg_s.
- States:
  - OFF: off_o=1. If req_on_i=1, go to UP_PG with k=0 and en_o[0]=1 registered the same edge.
  - UP_PG: timeout counter increments each cycle.
    - pg_s[k]=1: load settle counter with ramp_dly_i, go to UP_SET.
    - Counter reaches TMO_CYC: go to FAULT with err_ch_o=k.
  - UP_SET: counter decrements; ramp_dly_i=0 means one cycle in UP_SET. At 0:
    - k<N_CH-1: k++, en_o[k]=1, go to UP_PG.
    - else: go to ON.
  - Resulting rising-edge spacing of en_o = pgood latency + 2 + max(ramp_dly_i,1) + 1 cycles.
  - ON: done_o=1.
    - Any pg_s bit drops: go to FAULT, err_ch_o = lowest index low.
    - req_on_i=0: en_o[N_CH-1]=0, k=N_CH-1, load settle counter, go to DN_SET.
  - DN_SET: counter decrements. At 0:
    - k>0: k--, en_o[k]=0, reload counter.
    - k=0: go to OFF.
    - No pgood checks during ramp-down.
- req_on_i falls during UP_PG/UP_SET: en_o[k]=0 on the next edge, enter DN_SET from the current k.
- req_on_i rises during DN_SET: finish the current settle. Then enable channel k again and enter UP_PG at k.
- busy_o=1 in UP_PG, UP_SET, DN_SET.
- Timeout or pgood loss in any state: go to FAULT; all en_o cleared on the same edge; err_o=1 and err_ch_o latched.
- FAULT exits to OFF only on err_clr_i=1 with req_on_i=0. err_clr_i with req_on_i=1 is ignored.
- err_o, err_ch_o clear on that exit. err_clr_i outside FAULT has no effect.
- Simultaneous drop of several pg_s bits: lowest index is reported.
- Counters saturate and never wrap. en_o is registered, glitch-free, and always a contiguous run from bit 0 (thermometer code).

Decomposition:
- Package io_seq_pkg:
  - state enum {OFF, UP_PG, UP_SET, ON, DN_SET, FAULT}
  - TMO counter width constant (16)
  - CH_IDX_W function: max(1, $clog2(N_CH))
- Sub-module io_seq_sync2: parametrised-width 2-flop synchroniser with async active-high reset to 0. Instantiated once, width N_CH.

Test Plan:
- N_CH=4, ramp_dly_i=3, pgood model 5 cycles after en: req_on_i 0→1. Expect en_o 0001→0011→0111→1111, each step 11 cycles apart, done_o=1 one cycle after the last settle, busy_o high throughout.
- From ON, req_on_i→0, ramp_dly_i=3: expect en_o 0111→0011→0001→0000 at 4-cycle spacing, then off_o=1, done_o=0.
- Channel 2 pgood held low, TMO_CYC=16: expect FAULT 16 cycles after en_o[2] rise, en_o=0000 same edge, err_o=1, err_ch_o=2. err_clr_i with req_on_i=1 ignored; with req_on_i=0 gives OFF and err_o=0.
- In ON, drop pgood_i[1] and pgood_i[3] in the same cycle: after 2-cycle sync, en_o=0000, err_ch_o=1.
- req_on_i toggled 1→0 while in UP_SET of k=1: en_o 0011→0001→0000 with correct settle spacing. Re-raise during the DN_SET of k=0: sequence restarts at en_o=0001.
- Assert rst in UP_PG with en_o=0011: en_o=0000, off_o=1, err_o=0 immediately, without waiting for a clk edge.
